// File: rtl/seq_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, FSM states and
// the opcode-class decode used to steer DECODE/EXEC transitions.
package seq_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_CMP  = 3'b101;
    localparam logic [2:0] OP_LDI  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        WB     = 3'd4,
        NEXT   = 3'd5,
        HALT   = 3'd6
    } state_e;

    typedef struct packed {
        logic is_write;  // result goes to the register file
        logic uses_alu;  // must wait for alu_done in EXEC
    } op_class_t;

    // HALT is neither; it is intercepted in DECODE before the class matters.
    function automatic op_class_t op_class(input logic [2:0] op);
        op_class_t c;
        c.is_write = (op <= OP_XOR) || (op == OP_LDI);
        c.uses_alu = (op <= OP_CMP);
        return c;
    endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// EXEC wait counter: cleared on load, counts while enabled, flags the last
// allowed cycle so the FSM can time out in the same cycle.
module seq_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;

    assign expired_o = (cnt_q == CW'(TIMEOUT - 1));

    // Clear takes priority; stop counting at the last cycle so it never wraps.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                 cnt_q <= '0;
        else if (clr_i)               cnt_q <= '0;
        else if (en_i && !expired_o)  cnt_q <= cnt_q + CW'(1);
    end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute controller for the 8-bit accumulator core.
// Optional feature macro: SEQ_CMP_SKIP_EN (CMP equal skips next instruction).
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int PC_W        = 8,
    parameter int ALU_TIMEOUT = 15
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            start,
    input  logic [PC_W-1:0] pc_init,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [7:0]      imem_rdata,
    output logic [7:0]      instr_out,
    output logic            dec_ena,
    input  logic            alu_done,
    input  logic            alu_cmp_eq,
    output logic            wb_strobe,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            halted,
    output logic            timeout_err
);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [7:0]      instr_q, instr_d;
    logic            terr_q, terr_d;
    logic            skip_q, skip_d;
    logic            tmr_clr, tmr_exp;
    op_class_t       cls;

    assign cls = op_class(instr_q[7:5]);

    seq_wait_timer #(.TIMEOUT(ALU_TIMEOUT)) u_timer (
        .clock    (clock),
        .reset_n  (reset_n),
        .clr_i    (tmr_clr),
        .en_i     (state_q == EXEC),
        .expired_o(tmr_exp)
    );

`ifdef SEQ_CMP_SKIP_EN
    logic cmp_eq_hit;
    assign cmp_eq_hit = alu_cmp_eq;
`else
    // Equal flag has no effect without the skip feature.
    logic cmp_eq_hit;
    logic unused_cmp_eq;
    assign cmp_eq_hit    = 1'b0;
    assign unused_cmp_eq = alu_cmp_eq;
`endif

    // Outputs are pure state decodes so reset clears them immediately.
    assign imem_req    = (state_q == FETCH);
    assign imem_addr   = pc_q;
    assign instr_out   = instr_q;
    assign dec_ena     = (state_q == DECODE);
    assign wb_strobe   = (state_q == WB);
    assign pc          = pc_q;
    assign busy        = (state_q != IDLE) && (state_q != HALT);
    assign halted      = (state_q == HALT);
    assign timeout_err = terr_q;

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
            instr_q <= '0;
            terr_q  <= 1'b0;
            skip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            terr_q  <= terr_d;
            skip_q  <= skip_d;
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        terr_d  = terr_q;
        skip_d  = skip_q;
        tmr_clr = 1'b0;
        case (state_q)
            IDLE, HALT: begin
                if (start) begin
                    state_d = FETCH;
                    pc_d    = pc_init;
                    terr_d  = 1'b0;
                end
            end
            FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (instr_q[7:5] == OP_HALT) begin
                    state_d = HALT;
                end else if (!cls.uses_alu) begin
                    state_d = WB;
                end else begin
                    state_d = EXEC;
                    tmr_clr = 1'b1;
                end
            end
            EXEC: begin
                if (alu_done) begin
                    state_d = cls.is_write ? WB : NEXT;
                    skip_d  = !cls.is_write && cmp_eq_hit;
                end else if (tmr_exp) begin
                    terr_d  = 1'b1;
                    state_d = HALT;
                end
            end
            WB: state_d = NEXT;
            NEXT: begin
                pc_d    = pc_q + (skip_q ? PC_W'(2) : PC_W'(1));
                skip_d  = 1'b0;
                state_d = FETCH;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer (default build; the
// CMP-skip expectation follows SEQ_CMP_SKIP_EN if the bench is built with it).
module tb_instr_sequencer;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] pc_init = '0;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_rdata;
    logic [7:0] instr_out;
    logic       dec_ena;
    logic       alu_done = 1'b0;
    logic       alu_cmp_eq = 1'b0;
    logic       wb_strobe;
    logic [7:0] pc;
    logic       busy;
    logic       halted;
    logic       timeout_err;

    logic [7:0] mem [256];
    logic       ack_en = 1'b1;
    int         n_chk = 0;
    int         n_fail = 0;
    int         dec_cnt = 0;
    int         wb_cnt = 0;
    int         d0, w0;

    always #5 clock = ~clock;

    assign imem_ack   = imem_req & ack_en;
    assign imem_rdata = mem[imem_addr];

    instr_sequencer #(.PC_W(8), .ALU_TIMEOUT(15)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .pc_init(pc_init),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr_out(instr_out), .dec_ena(dec_ena),
        .alu_done(alu_done), .alu_cmp_eq(alu_cmp_eq), .wb_strobe(wb_strobe),
        .pc(pc), .busy(busy), .halted(halted), .timeout_err(timeout_err)
    );

    // Pulse counters, sampled mid-cycle.
    always @(negedge clock) begin
        if (dec_ena)   dec_cnt++;
        if (wb_strobe) wb_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start(input logic [7:0] a);
        pc_init = a;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic wait_halt(input string tag);
        for (int i = 0; i < 40 && !halted; i++) tick();
        check(tag, halted, 1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'hE0;
        mem[8'h10] = 8'hC5;  // LDI 5
        mem[8'h20] = 8'h03;  // ADD 3
        mem[8'h30] = 8'h40;  // AND, ALU never answers
        mem[8'hFE] = 8'hA0;  // CMP
        mem[8'hFF] = 8'hC1;  // LDI 1
        mem[8'h50] = 8'hC2;

        #12;
        check("rst_busy",  busy, 0);
        check("rst_pc",    pc, 0);
        check("rst_instr", instr_out, 0);
        check("rst_req",   imem_req, 0);
        check("rst_flags", {dec_ena, wb_strobe, halted, timeout_err}, 0);
        reset_n = 1'b1;
        tick();

        // 1: LDI with single-cycle fetch, 4 cycles per instruction.
        do_start(8'h10);
        check("t1_req",   imem_req, 1);
        check("t1_addr",  imem_addr, 8'h10);
        tick();
        check("t1_dec",   dec_ena, 1);
        check("t1_instr", instr_out, 8'hC5);
        tick();
        check("t1_wb",    {dec_ena, wb_strobe}, 2'b01);
        tick();
        check("t1_next",  {wb_strobe, busy, pc}, {2'b01, 8'h10});
        tick();
        check("t1_pc",    pc, 8'h11);
        check("t1_fetch", imem_req, 1);
        wait_halt("t1_halt");

        // 2: ADD, ALU answers in the 4th EXEC cycle.
        d0 = dec_cnt; w0 = wb_cnt;
        do_start(8'h20);
        tick(); tick();
        for (int i = 0; i < 3; i++) begin
            check("t2_busy", busy, 1);
            tick();
        end
        check("t2_nowb", wb_strobe, 0);
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        check("t2_wb",   wb_strobe, 1);
        check("t2_dec1", dec_cnt - d0, 1);
        tick();
        check("t2_busy_next", busy, 1);
        tick();
        check("t2_pc", pc, 8'h21);
        wait_halt("t2_halt");
        check("t2_wbcnt", wb_cnt - w0, 1);

        // 3: HALT state then restart at 0.
        check("t3_state", {halted, busy}, 2'b10);
        tick(); tick();
        check("t3_pc_frozen", pc, 8'h21);
        do_start(8'h00);
        check("t3_restart", {halted, busy, imem_req}, 3'b011);
        check("t3_addr", imem_addr, 8'h00);
        wait_halt("t3_halt");

        // 4: ALU timeout after 15 EXEC cycles.
        w0 = wb_cnt;
        do_start(8'h30);
        tick(); tick();   // now in EXEC cycle 1
        for (int i = 0; i < 14; i++) tick();
        check("t4_still_exec", {busy, timeout_err}, 2'b10);
        tick();
        check("t4_timeout", {halted, timeout_err}, 2'b11);
        check("t4_nowb", wb_cnt - w0, 0);
        do_start(8'h00);
        check("t4_clear", {halted, timeout_err}, 2'b00);
        wait_halt("t4_halt");

        // 5: pc wrap on LDI at 0xFF.
        do_start(8'hFF);
        tick(); tick(); tick(); tick();
        check("t5_wrap", pc, 8'h00);
        wait_halt("t5_halt");

        // 5b: CMP at 0xFE with eq=1 and eq=0.
        for (int e = 1; e >= 0; e--) begin
            do_start(8'hFE);
            tick();
            alu_done = 1'b1; alu_cmp_eq = e[0];
            tick();            // EXEC
            tick();            // NEXT
            alu_done = 1'b0; alu_cmp_eq = 1'b0;
            check("t5_cmp_nowb", {wb_strobe, busy}, 2'b01);
            tick();
`ifdef SEQ_CMP_SKIP_EN
            check("t5_cmp_pc", pc, e ? 8'h00 : 8'hFF);
`else
            check("t5_cmp_pc", pc, 8'hFF);
`endif
            wait_halt("t5_cmp_halt");
        end

        // 6: start while busy ignored; async reset aborts pending fetch.
        ack_en = 1'b0;
        do_start(8'h50);
        tick(); tick();
        check("t6_pending", {imem_req, imem_addr}, {1'b1, 8'h50});
        do_start(8'h77);
        check("t6_start_busy", {imem_req, imem_addr}, {1'b1, 8'h50});
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_rst_outs", {imem_req, busy, halted, dec_ena, wb_strobe}, 0);
        check("t6_rst_pc", pc, 0);
        check("t6_rst_instr", instr_out, 0);
        ack_en = 1'b1;
        tick();
        reset_n = 1'b1;
        tick(); tick();
        check("t6_idle", {busy, imem_req, pc}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
